// File: rtl/puf_vote_ctrl_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module  : puf_vote_ctrl_if
// Brief   : Bus-side and PUF-core-side signal bundle for puf_vote_ctrl.
// Revision: 1.0  initial release
// ---------------------------------------------------------------------------
interface puf_vote_ctrl_if #(
  parameter int CHAL_W        = 128,
  parameter int BITS_PER_EVAL = 2
);
  localparam int RESP_W = CHAL_W * BITS_PER_EVAL;
  localparam int UCNT_W = $clog2(RESP_W + 1);

  logic                     enable;
  logic                     mode;
  logic [CHAL_W-1:0]        challenge;
  logic                     rng_req;
  logic                     rng_chal_valid;
  logic                     rng_valid;
  logic [BITS_PER_EVAL-1:0] rng_bits;
  logic                     core_en;
  logic [CHAL_W-1:0]        core_chal;
  logic                     core_done;
  logic [BITS_PER_EVAL-1:0] core_resp;
  logic                     busy;
  logic                     done;
  logic                     err_zero_chal;
  logic [RESP_W-1:0]        response;
  logic [UCNT_W-1:0]        unstable_cnt;

  // Environment side: bus requester plus the PUF core.
  modport master (
    output enable, mode, challenge, rng_chal_valid, core_done, core_resp,
    input  rng_req, rng_valid, rng_bits, core_en, core_chal, busy, done,
           err_zero_chal, response, unstable_cnt
  );

  // Controller side.
  modport slave (
    input  enable, mode, challenge, rng_chal_valid, core_done, core_resp,
    output rng_req, rng_valid, rng_bits, core_en, core_chal, busy, done,
           err_zero_chal, response, unstable_cnt
  );
endinterface
`default_nettype wire

// File: rtl/puf_vote_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module  : puf_vote_ctrl
// Brief   : Delay-PUF evaluation controller with per-bit majority voting
//           (PUF mode) and raw-bit streaming (RNG mode).
// Revision: 1.0  initial release
// ---------------------------------------------------------------------------
module puf_vote_ctrl #(
  parameter int CHAL_W        = 128,
  parameter int BITS_PER_EVAL = 2,
  parameter int VOTE_NUM      = 10,
  parameter int THRESHOLD     = 5
) (
  input  wire logic       clk,
  input  wire logic       rst,
  puf_vote_ctrl_if.slave  bus
);
  localparam int RESP_W = CHAL_W * BITS_PER_EVAL;
  localparam int CNT_W  = $clog2(VOTE_NUM + 1);
  localparam int UCNT_W = $clog2(RESP_W + 1);
  localparam int ECNT_W = $clog2(CHAL_W + 1);

  localparam logic [CNT_W-1:0]  C_VOTE_MAX  = CNT_W'(VOTE_NUM);
  localparam logic [CNT_W-1:0]  C_THRESH    = CNT_W'(THRESHOLD);
  localparam logic [ECNT_W-1:0] C_LAST_EVAL = ECNT_W'(CHAL_W - 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_WAIT_CHAL = 3'd1,
    S_RNG_EVAL  = 3'd2,
    S_EVAL      = 3'd3,
    S_ROUND_END = 3'd4,
    S_RESOLVE   = 3'd5,
    S_DONE      = 3'd6
  } state_t;

  state_t             r_state;
  logic               r_mode;
  logic [RESP_W-1:0]  r_shift;
  logic [CNT_W-1:0]   r_cnt [RESP_W];
  logic [ECNT_W-1:0]  r_eval_cnt;
  logic [CNT_W-1:0]   r_round_cnt;

  logic               w_in_busy;
  logic               w_abort;
  logic [RESP_W-1:0]  w_vote;
  logic [UCNT_W-1:0]  w_unstable;

  // Abort when the run request drops or the mode flips while working.
  assign w_in_busy = (r_state != S_IDLE) && (r_state != S_DONE);
  assign w_abort   = w_in_busy && (!bus.enable || (bus.mode != r_mode));

  // Majority decision and instability count over all vote counters.
  always_comb begin
    w_vote     = '0;
    w_unstable = '0;
    for (int i = 0; i < RESP_W; i++) begin
      w_vote[i] = (r_cnt[i] >= C_THRESH);
      if ((r_cnt[i] != '0) && (r_cnt[i] != C_VOTE_MAX))
        w_unstable = w_unstable + UCNT_W'(1);
    end
  end

  // Control FSM with registered outputs, shift register and vote counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state           <= S_IDLE;
      r_mode            <= 1'b0;
      r_shift           <= '0;
      r_eval_cnt        <= '0;
      r_round_cnt       <= '0;
      for (int i = 0; i < RESP_W; i++) r_cnt[i] <= '0;
      bus.rng_req       <= 1'b0;
      bus.rng_valid     <= 1'b0;
      bus.rng_bits      <= '0;
      bus.core_en       <= 1'b0;
      bus.core_chal     <= '0;
      bus.busy          <= 1'b0;
      bus.done          <= 1'b0;
      bus.err_zero_chal <= 1'b0;
      bus.response      <= '0;
      bus.unstable_cnt  <= '0;
    end else begin
      bus.done      <= 1'b0;
      bus.rng_valid <= 1'b0;
      if (w_abort) begin
        // Abort beats a simultaneous capture: the result is dropped.
        r_state      <= S_IDLE;
        bus.busy     <= 1'b0;
        bus.core_en  <= 1'b0;
        bus.rng_req  <= 1'b0;
        bus.response <= '0;
        r_shift      <= '0;
        r_eval_cnt   <= '0;
        r_round_cnt  <= '0;
        for (int i = 0; i < RESP_W; i++) r_cnt[i] <= '0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (bus.enable) begin
              r_mode <= bus.mode;
              if (!bus.mode) begin
                r_state     <= S_WAIT_CHAL;
                bus.rng_req <= 1'b1;
                bus.busy    <= 1'b1;
              end else if (bus.challenge == '0) begin
                r_state           <= S_DONE;
                bus.err_zero_chal <= 1'b1;
                bus.response      <= '0;
                bus.done          <= 1'b1;
              end else begin
                r_state           <= S_EVAL;
                bus.busy          <= 1'b1;
                bus.core_chal     <= bus.challenge;
                bus.err_zero_chal <= 1'b0;
                bus.response      <= '0;
                bus.unstable_cnt  <= '0;
                r_shift           <= '0;
                r_eval_cnt        <= '0;
                r_round_cnt       <= '0;
                for (int i = 0; i < RESP_W; i++) r_cnt[i] <= '0;
              end
            end
          end

          S_WAIT_CHAL: begin
            if (bus.rng_chal_valid) begin
              bus.core_chal <= bus.challenge;
              bus.rng_req   <= 1'b0;
              r_state       <= S_RNG_EVAL;
            end
          end

          S_RNG_EVAL: begin
            // Not aborting here implies enable=1 and mode=RNG: fetch again.
            if (!bus.core_en && !bus.core_done) begin
              bus.core_en <= 1'b1;
            end else if (bus.core_en && bus.core_done) begin
              bus.core_en   <= 1'b0;
              bus.rng_bits  <= bus.core_resp;
              bus.rng_valid <= 1'b1;
              bus.rng_req   <= 1'b1;
              r_state       <= S_WAIT_CHAL;
            end
          end

          S_EVAL: begin
            if (!bus.core_en && !bus.core_done) begin
              bus.core_en <= 1'b1;
            end else if (bus.core_en && bus.core_done) begin
              bus.core_en   <= 1'b0;
              r_shift       <= {r_shift[RESP_W-BITS_PER_EVAL-1:0], bus.core_resp};
              bus.core_chal <= {bus.core_chal[CHAL_W-2:0], bus.core_chal[CHAL_W-1]};
              r_eval_cnt    <= r_eval_cnt + ECNT_W'(1);
              // After CHAL_W rotations the challenge is back to its start value.
              if (r_eval_cnt == C_LAST_EVAL) r_state <= S_ROUND_END;
            end
          end

          S_ROUND_END: begin
            for (int i = 0; i < RESP_W; i++) begin
              if (r_cnt[i] != C_VOTE_MAX) r_cnt[i] <= r_cnt[i] + CNT_W'(r_shift[i]);
            end
            r_shift     <= '0;
            r_eval_cnt  <= '0;
            r_round_cnt <= r_round_cnt + CNT_W'(1);
            if ((r_round_cnt + CNT_W'(1)) < C_VOTE_MAX) r_state <= S_EVAL;
            else                                          r_state <= S_RESOLVE;
          end

          S_RESOLVE: begin
            bus.response     <= w_vote;
            bus.unstable_cnt <= w_unstable;
            bus.done         <= 1'b1;
            bus.busy         <= 1'b0;
            r_state          <= S_DONE;
          end

          S_DONE: begin
            if (!bus.enable) r_state <= S_IDLE;
          end

          default: begin
            r_state  <= S_IDLE;
            bus.busy <= 1'b0;
          end
        endcase
      end
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_puf_vote_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module  : tb_puf_vote_ctrl
// Brief   : Directed self-checking bench for puf_vote_ctrl with a
//           3-cycle-latency core model returning core_chal[1:0].
// Revision: 1.0  initial release
// ---------------------------------------------------------------------------
module tb_puf_vote_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  puf_vote_ctrl_if #(.CHAL_W(8), .BITS_PER_EVAL(2)) bus ();

  puf_vote_ctrl #(
    .CHAL_W(8), .BITS_PER_EVAL(2), .VOTE_NUM(5), .THRESHOLD(3)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int   n_chk = 0;
  int   n_err = 0;
  int   rises;
  int   done_cnt;
  int   rv_cnt;
  int   flip_rounds = 0;
  logic mon_clr = 1'b0;
  logic prev_en;
  logic [1:0] lat;
  logic flip_now;

  // Flip bit 0 of evaluation 7 (response bit 0) in the first flip_rounds rounds.
  assign flip_now = (rises > 0) && (((rises - 1) % 8) == 7) && (((rises - 1) / 8) < flip_rounds);

  // Core model: done 3 cycles after start, held until core_en drops.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.core_done <= 1'b0;
      bus.core_resp <= 2'b00;
      lat           <= 2'd0;
    end else if (bus.core_done) begin
      if (!bus.core_en) bus.core_done <= 1'b0;
    end else if (bus.core_en) begin
      if (lat == 2'd2) begin
        bus.core_done <= 1'b1;
        bus.core_resp <= bus.core_chal[1:0] ^ {1'b0, flip_now};
        lat           <= 2'd0;
      end else begin
        lat <= lat + 2'd1;
      end
    end else begin
      lat <= 2'd0;
    end
  end

  // Event counters: core_en rises, done pulses, rng_valid pulses.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      rises <= 0; done_cnt <= 0; rv_cnt <= 0; prev_en <= 1'b0;
    end else if (mon_clr) begin
      rises <= 0; done_cnt <= 0; rv_cnt <= 0; prev_en <= bus.core_en;
    end else begin
      prev_en <= bus.core_en;
      if (bus.core_en && !prev_en) rises <= rises + 1;
      if (bus.done) done_cnt <= done_cnt + 1;
      if (bus.rng_valid) rv_cnt <= rv_cnt + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=%0h expected=%0h", tag, act, exp);
    end
  endtask

  task automatic wait_done(input int budget, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      if (bus.done) ok = 1'b1;
    end
  endtask

  task automatic wait_rises(input int target, input int budget, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      if (rises >= target) ok = 1'b1;
    end
  endtask

  task automatic run_puf(input string tag, input logic [7:0] chal, input int fr,
                         input logic [15:0] exp_resp, input logic [4:0] exp_unst);
    logic ok;
    @(negedge clk);
    mon_clr = 1'b1; flip_rounds = fr;
    bus.challenge = chal; bus.mode = 1'b1; bus.enable = 1'b1;
    @(negedge clk);
    mon_clr = 1'b0;
    check({tag, "_busy_after_start"}, bus.busy, 1);
    check({tag, "_core_en_first_cycle"}, bus.core_en, 0);
    @(negedge clk);
    check({tag, "_core_en_rise"}, bus.core_en, 1);
    wait_done(2000, ok);
    check({tag, "_done_seen"}, ok, 1);
    check({tag, "_response"}, bus.response, exp_resp);
    check({tag, "_unstable"}, bus.unstable_cnt, exp_unst);
    check({tag, "_chal_restored"}, bus.core_chal, chal);
    repeat (3) @(negedge clk);
    check({tag, "_done_once"}, done_cnt, 1);
    check({tag, "_core_en_rises"}, rises, 40);
    bus.enable = 1'b0;
    @(negedge clk);
    check({tag, "_busy_end"}, bus.busy, 0);
  endtask

  initial begin
    logic ok;
    bus.enable = 1'b0; bus.mode = 1'b0; bus.challenge = 8'h00; bus.rng_chal_valid = 1'b0;

    // Reset values.
    repeat (3) @(negedge clk);
    check("rst_core_en", bus.core_en, 0);
    check("rst_core_chal", bus.core_chal, 0);
    check("rst_response", bus.response, 0);
    check("rst_busy_done", {bus.busy, bus.done, bus.rng_req, bus.rng_valid, bus.err_zero_chal}, 0);
    check("rst_rng_bits_unst", {bus.rng_bits, bus.unstable_cnt}, 0);
    rst = 1'b1;
    @(negedge clk);

    // A5 rotations give LSB pairs 01,11,10,01,10,00,01,10 -> 16'h7986.
    run_puf("puf_a5", 8'hA5, 0, 16'h7986, 5'd1 - 5'd1);
    run_puf("puf_flip2", 8'hA5, 2, 16'h7986, 5'd1);
    run_puf("puf_flip3", 8'hA5, 3, 16'h7987, 5'd1);

    // Zero challenge error.
    @(negedge clk);
    mon_clr = 1'b1;
    bus.challenge = 8'h00; bus.mode = 1'b1; bus.enable = 1'b1;
    @(negedge clk);
    mon_clr = 1'b0;
    check("zc_done", bus.done, 1);
    check("zc_err", bus.err_zero_chal, 1);
    check("zc_response", bus.response, 0);
    @(negedge clk);
    check("zc_done_pulse", bus.done, 0);
    repeat (5) @(negedge clk);
    check("zc_no_core", rises, 0);
    bus.enable = 1'b0;
    @(negedge clk);
    check("zc_busy", bus.busy, 0);

    // RNG mode.
    @(negedge clk);
    mon_clr = 1'b1; flip_rounds = 0;
    bus.mode = 1'b0; bus.enable = 1'b1;
    @(negedge clk);
    mon_clr = 1'b0;
    check("rng_req_up", bus.rng_req, 1);
    repeat (4) @(negedge clk);
    bus.challenge = 8'h03; bus.rng_chal_valid = 1'b1;
    @(negedge clk);
    bus.rng_chal_valid = 1'b0;
    check("rng_req_fall", bus.rng_req, 0);
    check("rng_core_chal", bus.core_chal, 8'h03);
    ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if (bus.rng_valid) ok = 1'b1;
    end
    check("rng_valid_seen", ok, 1);
    check("rng_bits", bus.rng_bits, 2'b11);
    check("rng_req_again", bus.rng_req, 1);
    repeat (3) @(negedge clk);
    check("rng_valid_once", rv_cnt, 1);
    bus.enable = 1'b0;
    @(negedge clk);
    check("rng_exit_req", bus.rng_req, 0);
    check("rng_exit_busy", bus.busy, 0);

    // Abort during vote round 2.
    @(negedge clk);
    mon_clr = 1'b1; flip_rounds = 0;
    bus.challenge = 8'hA5; bus.mode = 1'b1; bus.enable = 1'b1;
    @(negedge clk);
    mon_clr = 1'b0;
    wait_rises(17, 2000, ok);
    check("abort_reach_round2", ok, 1);
    bus.enable = 1'b0;
    @(negedge clk);
    check("abort_core_en", bus.core_en, 0);
    check("abort_busy", bus.busy, 0);
    check("abort_response", bus.response, 0);
    repeat (20) @(negedge clk);
    check("abort_no_done", done_cnt, 0);
    run_puf("after_abort", 8'hA5, 0, 16'h7986, 5'd0);

    // Asynchronous reset mid-EVAL.
    @(negedge clk);
    mon_clr = 1'b1;
    bus.challenge = 8'hA5; bus.mode = 1'b1; bus.enable = 1'b1;
    @(negedge clk);
    mon_clr = 1'b0;
    wait_rises(5, 500, ok);
    check("arst_reach_eval", ok, 1);
    #2 rst = 1'b0;
    #1;
    check("arst_core_chal", bus.core_chal, 0);
    check("arst_core_en_busy", {bus.core_en, bus.busy}, 0);
    bus.enable = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    repeat (300) @(negedge clk);
    check("arst_no_done", done_cnt, 0);
    check("arst_idle", {bus.busy, bus.core_en}, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
`default_nettype wire
